// File: rtl/riscv_core_lsu_if.sv
// Load/store unit signal bundle: pipeline-side request/response plus the data bus.
// The LSU takes the slave view; the core/bus environment takes the master view.
interface riscv_core_lsu_if #(
    parameter int XLEN = 32
);
    logic            i_lsu_valid;
    logic            i_lsu_we;
    logic [1:0]      i_lsu_r_w_size;
    logic            i_lsu_su_extend;
    logic [XLEN-1:0] i_lsu_addr;
    logic [XLEN-1:0] i_lsu_wdata;
    logic            o_lsu_stall;
    logic            o_lsu_done;
    logic [XLEN-1:0] o_lsu_rdata;
    logic [1:0]      o_lsu_r_w_size;
    logic            o_lsu_su_extend;

    logic            o_dbus_req;
    logic            o_dbus_we;
    logic [XLEN-1:0] o_dbus_addr;
    logic [3:0]      o_dbus_be;
    logic [XLEN-1:0] o_dbus_wdata;
    logic            i_dbus_gnt;
    logic            i_dbus_rvalid;
    logic [XLEN-1:0] i_dbus_rdata;

    modport slave (
        input  i_lsu_valid, i_lsu_we, i_lsu_r_w_size, i_lsu_su_extend, i_lsu_addr, i_lsu_wdata,
        output o_lsu_stall, o_lsu_done, o_lsu_rdata, o_lsu_r_w_size, o_lsu_su_extend,
        output o_dbus_req, o_dbus_we, o_dbus_addr, o_dbus_be, o_dbus_wdata,
        input  i_dbus_gnt, i_dbus_rvalid, i_dbus_rdata
    );

    modport master (
        output i_lsu_valid, i_lsu_we, i_lsu_r_w_size, i_lsu_su_extend, i_lsu_addr, i_lsu_wdata,
        input  o_lsu_stall, o_lsu_done, o_lsu_rdata, o_lsu_r_w_size, o_lsu_su_extend,
        input  o_dbus_req, o_dbus_we, o_dbus_addr, o_dbus_be, o_dbus_wdata,
        output i_dbus_gnt, i_dbus_rvalid, i_dbus_rdata
    );
endinterface

// File: rtl/riscv_core_lsu.sv
// MEM-stage load/store unit: turns one byte/half/word access into one or two
// word-aligned bus beats, merging misaligned load data back into a right-aligned result.
module riscv_core_lsu #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    riscv_core_lsu_if.slave lsu
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ1,
        S_WAIT1,
        S_REQ2,
        S_WAIT2,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic            we_q, we_d;
    logic [1:0]      size_q, size_d;
    logic            su_q, su_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] rdata_q, rdata_d;

    logic [1:0]      off;
    logic [3:0]      mask;
    logic            split;
    logic [4:0]      sh_lo;
    logic [5:0]      sh_hi;
    logic [7:0]      be_wide;
    logic [3:0]      be_lo;
    logic [3:0]      be_hi;
    logic [XLEN-1:0] word_addr;

    logic            stall_c;
    logic            done_c;
    logic            req_c;
    logic            bus_we_c;
    logic [XLEN-1:0] bus_addr_c;
    logic [3:0]      bus_be_c;
    logic [XLEN-1:0] bus_wdata_c;

    // Lane geometry of the registered request; size 11 behaves as a word.
    always_comb begin
        off = addr_q[1:0];
        case (size_q)
            2'b00:   mask = 4'b0001;
            2'b01:   mask = 4'b0011;
            default: mask = 4'b1111;
        endcase
        split     = ((size_q == 2'b01) && (off == 2'b11)) || (size_q[1] && (off != 2'b00));
        sh_lo     = {off, 3'b000};
        sh_hi     = 6'd32 - {1'b0, off, 3'b000};
        be_wide   = {4'b0000, mask} << off;
        be_lo     = be_wide[3:0];
        be_hi     = mask >> (3'd4 - {1'b0, off});
        word_addr = {addr_q[XLEN-1:2], 2'b00};
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        su_d        = su_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        stall_c     = 1'b0;
        done_c      = 1'b0;
        req_c       = 1'b0;
        bus_we_c    = 1'b0;
        bus_addr_c  = '0;
        bus_be_c    = 4'b0000;
        bus_wdata_c = '0;

        case (state_q)
            S_IDLE: begin
                stall_c = lsu.i_lsu_valid;
                if (lsu.i_lsu_valid) begin
                    we_d    = lsu.i_lsu_we;
                    size_d  = lsu.i_lsu_r_w_size;
                    su_d    = lsu.i_lsu_su_extend;
                    addr_d  = lsu.i_lsu_addr;
                    wdata_d = lsu.i_lsu_wdata;
                    state_d = S_REQ1;
                end
            end
            S_REQ1: begin
                stall_c     = 1'b1;
                req_c       = 1'b1;
                bus_we_c    = we_q;
                bus_addr_c  = word_addr;
                bus_be_c    = be_lo;
                bus_wdata_c = wdata_q << sh_lo;
                if (lsu.i_dbus_gnt) begin
                    state_d = S_WAIT1;
                end
            end
            S_WAIT1: begin
                stall_c = 1'b1;
                if (lsu.i_dbus_rvalid) begin
                    if (!we_q) begin
                        rdata_d = lsu.i_dbus_rdata >> sh_lo;
                    end
                    state_d = split ? S_REQ2 : S_DONE;
                end
            end
            S_REQ2: begin
                stall_c     = 1'b1;
                req_c       = 1'b1;
                bus_we_c    = we_q;
                bus_addr_c  = word_addr + 32'd4;
                bus_be_c    = be_hi;
                bus_wdata_c = wdata_q >> sh_hi;
                if (lsu.i_dbus_gnt) begin
                    state_d = S_WAIT2;
                end
            end
            S_WAIT2: begin
                stall_c = 1'b1;
                // Upper bytes of a misaligned access come from the low lanes of the second word.
                if (lsu.i_dbus_rvalid) begin
                    if (!we_q) begin
                        rdata_d = rdata_q | (lsu.i_dbus_rdata << sh_hi);
                    end
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_c  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            su_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            su_q    <= su_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Stall depends on the live valid in IDLE, so it is masked while reset is held.
    assign lsu.o_lsu_stall     = i_rst_n & stall_c;
    assign lsu.o_lsu_done      = done_c;
    assign lsu.o_lsu_rdata     = rdata_q;
    assign lsu.o_lsu_r_w_size  = size_q;
    assign lsu.o_lsu_su_extend = su_q;
    assign lsu.o_dbus_req      = req_c;
    assign lsu.o_dbus_we       = bus_we_c;
    assign lsu.o_dbus_addr     = bus_addr_c;
    assign lsu.o_dbus_be       = bus_be_c;
    assign lsu.o_dbus_wdata    = bus_wdata_c;

endmodule

// File: tb/tb_riscv_core_lsu.sv
// Bench for riscv_core_lsu: byte-level memory reference model, a bus responder that
// checks every beat, and a completion monitor that checks every done pulse.
module tb_riscv_core_lsu;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    riscv_core_lsu_if #(.XLEN(32)) bus ();

    riscv_core_lsu #(.XLEN(32)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .lsu     (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        su;
        logic [31:0] rdata;
        logic [31:0] rmask;
        int          issue_cyc;
        int          exp_lat;
    } sb_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } beat_t;

    sb_t   sb_q[$];
    beat_t beat_q[$];

    logic [7:0]  ref_mem [logic [31:0]];
    logic [31:0] bus_mem [logic [31:0]];
    logic [31:0] model_res  = 32'h0;
    logic [31:0] model_mask = 32'hFFFF_FFFF;

    int gnt_delay_cfg = 0;
    int rv_delay_cfg  = 0;
    bit rand_delays   = 1'b0;
    bit noise_en      = 1'b0;
    int grant_count   = 0;

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_byte(a);
    endfunction

    function automatic logic [31:0] bus_rd(input logic [31:0] wa);
        if (bus_mem.exists(wa)) return bus_mem[wa];
        return {init_byte(wa + 32'd3), init_byte(wa + 32'd2), init_byte(wa + 32'd1), init_byte(wa)};
    endfunction

    task automatic preset_word(input logic [31:0] a, input logic [31:0] w);
        bus_mem[a] = w;
        for (int i = 0; i < 4; i++) ref_mem[a + 32'(i)] = w[8*i +: 8];
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("[TB] ok %s = 0x%08h", name, act);
        end
    endtask

    // Reference model: an access touches bytes addr..addr+n-1; each touched byte lands in
    // the lane addr[1:0] of its own word, and the first word's beat goes out first.
    task automatic issue(input logic we, input logic [1:0] size, input logic su,
                         input logic [31:0] addr, input logic [31:0] wdata, input int lat);
        int          n;
        int          lane;
        logic [31:0] ba;
        logic [31:0] fa;
        beat_t       b0;
        beat_t       b1;
        sb_t         e;
        n  = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        fa = addr & ~32'h3;
        b0.addr = fa;          b0.be = 4'b0; b0.we = we; b0.wdata = 32'h0;
        b1.addr = fa + 32'd4;  b1.be = 4'b0; b1.we = we; b1.wdata = 32'h0;
        e.rdata = 32'h0;
        e.rmask = 32'h0;
        for (int i = 0; i < n; i++) begin
            ba   = addr + 32'(i);
            lane = int'(ba[1:0]);
            if ((ba & ~32'h3) == fa) begin
                b0.be[lane]          = 1'b1;
                b0.wdata[8*lane +: 8] = wdata[8*i +: 8];
            end else begin
                b1.be[lane]          = 1'b1;
                b1.wdata[8*lane +: 8] = wdata[8*i +: 8];
            end
            if (we) begin
                ref_mem[ba] = wdata[8*i +: 8];
            end else begin
                e.rdata[8*i +: 8] = ref_rd(ba);
                e.rmask[8*i +: 8] = 8'hFF;
            end
        end
        if (we) begin
            e.rdata = model_res;
            e.rmask = model_mask;
        end else begin
            model_res  = e.rdata;
            model_mask = e.rmask;
        end
        e.we        = we;
        e.size      = size;
        e.su        = su;
        e.issue_cyc = cyc;
        e.exp_lat   = lat;
        sb_q.push_back(e);
        beat_q.push_back(b0);
        if (b1.be != 4'b0) beat_q.push_back(b1);
        bus.i_lsu_valid     = 1'b1;
        bus.i_lsu_we        = we;
        bus.i_lsu_r_w_size  = size;
        bus.i_lsu_su_extend = su;
        bus.i_lsu_addr      = addr;
        bus.i_lsu_wdata     = wdata;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (bus.o_lsu_done) seen = 1'b1;
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: no done pulse within 200 cycles");
        end
        bus.i_lsu_valid = 1'b0;
    endtask

    // Completion monitor.
    initial begin
        sb_t e;
        bit  ok;
        forever begin
            @(negedge clk);
            if (rst_n && bus.o_lsu_done) begin
                tests++;
                if (sb_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_done: done pulse with nothing outstanding (cycle %0d)", cyc);
                end else begin
                    e  = sb_q.pop_front();
                    ok = ((bus.o_lsu_rdata & e.rmask) == (e.rdata & e.rmask)) &&
                         (bus.o_lsu_r_w_size == e.size) && (bus.o_lsu_su_extend == e.su) &&
                         (bus.o_lsu_stall == 1'b0) &&
                         ((e.exp_lat < 0) || ((cyc - e.issue_cyc) == e.exp_lat));
                    if (!ok) begin
                        fails++;
                        $display("FAIL done_%s: rdata=0x%08h size=%0d su=%0d stall=%0d lat=%0d expected rdata=0x%08h (mask 0x%08h) size=%0d su=%0d stall=0 lat=%0d",
                                 e.we ? "store" : "load", bus.o_lsu_rdata, bus.o_lsu_r_w_size,
                                 bus.o_lsu_su_extend, bus.o_lsu_stall, cyc - e.issue_cyc,
                                 e.rdata, e.rmask, e.size, e.su, e.exp_lat);
                    end else begin
                        $display("[TB] done %s size=%0d rdata=0x%08h lat=%0d",
                                 e.we ? "store" : "load", e.size, bus.o_lsu_rdata, cyc - e.issue_cyc);
                    end
                end
            end
        end
    end

    // Bus responder: grants after a programmable wait, answers after a programmable delay,
    // checks each granted beat against the model and keeps its own word memory.
    initial begin
        bit          pend;
        bit          fired;
        bit          in_req;
        int          pend_cnt;
        int          wcnt;
        int          target;
        logic [31:0] pend_data;
        logic [31:0] w;
        logic [31:0] lmask;
        beat_t       b;
        bit          ok;
        pend = 1'b0; in_req = 1'b0; pend_cnt = 0; wcnt = 0; target = 0; pend_data = 32'h0;
        bus.i_dbus_gnt    = 1'b0;
        bus.i_dbus_rvalid = 1'b0;
        bus.i_dbus_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            bus.i_dbus_gnt    = 1'b0;
            bus.i_dbus_rvalid = 1'b0;
            fired = 1'b0;
            if (pend) begin
                if (pend_cnt == 0) begin
                    bus.i_dbus_rvalid = 1'b1;
                    bus.i_dbus_rdata  = pend_data;
                    pend  = 1'b0;
                    fired = 1'b1;
                end else begin
                    pend_cnt--;
                end
            end
            if (noise_en && !fired && !pend && ($urandom_range(0, 3) == 0)) begin
                bus.i_dbus_rvalid = 1'b1;
                bus.i_dbus_rdata  = $urandom;
            end
            if (rst_n && bus.o_dbus_req) begin
                if (!in_req) begin
                    in_req = 1'b1;
                    wcnt   = 0;
                    target = rand_delays ? int'($urandom_range(0, 2)) : gnt_delay_cfg;
                end
                if (wcnt == target) begin
                    bus.i_dbus_gnt = 1'b1;
                    in_req = 1'b0;
                    grant_count++;
                    for (int l = 0; l < 4; l++) lmask[8*l +: 8] = {8{bus.o_dbus_be[l]}};
                    tests++;
                    if (beat_q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_beat: addr=0x%08h be=%b we=%0d", bus.o_dbus_addr, bus.o_dbus_be, bus.o_dbus_we);
                    end else begin
                        b  = beat_q.pop_front();
                        ok = (bus.o_dbus_addr == b.addr) && (bus.o_dbus_be == b.be) && (bus.o_dbus_we == b.we) &&
                             (!b.we || ((bus.o_dbus_wdata & lmask) == (b.wdata & lmask)));
                        if (!ok) begin
                            fails++;
                            $display("FAIL beat: addr=0x%08h be=%b we=%0d wdata=0x%08h expected addr=0x%08h be=%b we=%0d wdata=0x%08h",
                                     bus.o_dbus_addr, bus.o_dbus_be, bus.o_dbus_we, bus.o_dbus_wdata,
                                     b.addr, b.be, b.we, b.wdata);
                        end else begin
                            $display("[TB] beat addr=0x%08h be=%b we=%0d", b.addr, b.be, b.we);
                        end
                    end
                    w = bus_rd(bus.o_dbus_addr);
                    if (bus.o_dbus_we) begin
                        for (int l = 0; l < 4; l++)
                            if (bus.o_dbus_be[l]) w[8*l +: 8] = bus.o_dbus_wdata[8*l +: 8];
                        bus_mem[bus.o_dbus_addr] = w;
                    end
                    pend      = 1'b1;
                    pend_cnt  = rand_delays ? int'($urandom_range(0, 2)) : rv_delay_cfg;
                    pend_data = w;
                end else begin
                    wcnt++;
                end
            end else begin
                in_req = 1'b0;
                if (noise_en && ($urandom_range(0, 3) == 0)) bus.i_dbus_gnt = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int g0;
        bit got;
        logic [31:0] a;
        bus.i_lsu_valid     = 1'b1;
        bus.i_lsu_we        = 1'b1;
        bus.i_lsu_r_w_size  = 2'b10;
        bus.i_lsu_su_extend = 1'b1;
        bus.i_lsu_addr      = 32'h1234_5678;
        bus.i_lsu_wdata     = 32'hDEAD_BEEF;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);

        // Outputs while reset is held, with a request pending at the input.
        check("rst_req",    32'(bus.o_dbus_req),      32'h0);
        check("rst_we",     32'(bus.o_dbus_we),       32'h0);
        check("rst_be",     32'(bus.o_dbus_be),       32'h0);
        check("rst_done",   32'(bus.o_lsu_done),      32'h0);
        check("rst_stall",  32'(bus.o_lsu_stall),     32'h0);
        check("rst_addr",   bus.o_dbus_addr,          32'h0);
        check("rst_wdata",  bus.o_dbus_wdata,         32'h0);
        check("rst_rdata",  bus.o_lsu_rdata,          32'h0);
        check("rst_size",   32'(bus.o_lsu_r_w_size),  32'h0);
        check("rst_su",     32'(bus.o_lsu_su_extend), 32'h0);

        preset_word(32'h0000_1000, 32'hAABB_CCDD);
        preset_word(32'h0000_2000, 32'h1122_3344);
        preset_word(32'h0000_2004, 32'h5566_7788);

        // Byte load, issued on the very cycle reset is released.
        rst_n = 1'b1;
        issue(1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0, 3);
        wait_done();
        check("lb_rdata", 32'(bus.o_lsu_rdata[7:0]), 32'h0000_00AA);

        // Misaligned word load across two words.
        @(negedge clk);
        issue(1'b0, 2'b10, 1'b0, 32'h0000_2002, 32'h0, 5);
        wait_done();
        check("lw_split_rdata", bus.o_lsu_rdata, 32'h7788_1122);

        // Split half store, then read it back unsigned.
        @(negedge clk);
        issue(1'b1, 2'b01, 1'b0, 32'h0000_3003, 32'h0000_BEEF, 5);
        wait_done();
        @(negedge clk);
        issue(1'b0, 2'b01, 1'b1, 32'h0000_3003, 32'h0, 5);
        wait_done();
        check("lhu_readback", 32'(bus.o_lsu_rdata[15:0]), 32'h0000_BEEF);

        // Grant withheld for three cycles: the request must hold steady.
        @(negedge clk);
        gnt_delay_cfg = 3;
        issue(1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0, 6);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check($sformatf("hold%0d_req", k),   32'(bus.o_dbus_req),  32'h1);
            check($sformatf("hold%0d_stall", k), 32'(bus.o_lsu_stall), 32'h1);
            check($sformatf("hold%0d_addr", k),  bus.o_dbus_addr,      32'h0000_1000);
            check($sformatf("hold%0d_be", k),    32'(bus.o_dbus_be),   32'hF);
        end
        wait_done();
        gnt_delay_cfg = 0;
        check("hold_rdata", bus.o_lsu_rdata, 32'hAABB_CCDD);

        // Reset while waiting for the first response; the late response must be ignored.
        @(negedge clk);
        rv_delay_cfg = 3;
        g0 = grant_count;
        issue(1'b0, 2'b10, 1'b0, 32'h0000_2000, 32'h0, -1);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (grant_count != g0) got = 1'b1;
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL rstmid_grant: first beat never granted");
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_req",   32'(bus.o_dbus_req),  32'h0);
        check("rstmid_stall", 32'(bus.o_lsu_stall), 32'h0);
        check("rstmid_done",  32'(bus.o_lsu_done),  32'h0);
        sb_q.delete();
        beat_q.delete();
        model_res  = 32'h0;
        model_mask = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.i_lsu_valid = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("rstmid_quiet%0d", k), {30'h0, bus.o_lsu_done, bus.o_lsu_stall}, 32'h0);
        end
        check("rstmid_rdata", bus.o_lsu_rdata, 32'h0);
        rv_delay_cfg = 0;

        // Second beat wraps to address zero.
        issue(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFE, 32'h0, 5);
        wait_done();
        @(negedge clk);
        issue(1'b1, 2'b10, 1'b0, 32'hFFFF_FFFD, 32'hCAFE_F00D, 5);
        wait_done();
        @(negedge clk);
        issue(1'b0, 2'b11, 1'b1, 32'hFFFF_FFFD, 32'h0, 5);
        wait_done();
        check("wrap_readback", bus.o_lsu_rdata, 32'hCAFE_F00D);

        // Randomized traffic with random bus delays and spurious gnt/rvalid.
        rand_delays = 1'b1;
        noise_en    = 1'b1;
        for (int t = 0; t < 300; t++) begin
            repeat ($urandom_range(1, 3)) @(negedge clk);
            if ($urandom_range(0, 9) == 0) a = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
            else                           a = 32'h0000_1000 + 32'($urandom_range(0, 63));
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  a, $urandom, -1);
            wait_done();
        end
        rand_delays = 1'b0;
        noise_en    = 1'b0;
        repeat (5) @(negedge clk);
        check("sb_drained",   32'(sb_q.size()),   32'h0);
        check("beat_drained", 32'(beat_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
